fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side consumer for the async FIFO, running entirely in the read clock domain. It issues rinc whenever the FIFO is non-empty and local credit allows, and captures rdata on rvalid into a small output buffer. It presents the data as a valid/ready stream to the downstream logic. Credit tracking covers the FIFO read latency, so no word returned on rvalid is ever dropped.

Parameters:
DATA_W, 16, width of rdata and m_data.
OB_DEPTH, 4, output buffer entries; power of two, minimum 2.
CNT_W, 16, width of the delivered-word counter.

Ports:
rclk  input  1  read-domain clock; all logic on rising edge.
rrst_n  input  1  synchronous active-low reset, sampled on rclk.
en  input  1  drain enable; when low, no new rinc is issued.
rempty  input  1  FIFO empty flag (read domain).
rinc  output  1  FIFO read request, one word per asserted cycle.
rdata  input  DATA_W  FIFO read data, qualified by rvalid.
rvalid  input  1  FIFO read data valid.
m_valid  output  1  stream data valid.
m_ready  input  1  stream consumer ready.
m_data  output  DATA_W  stream data (head of output buffer).
rd_count  output  CNT_W  words delivered on the stream, wraps modulo 2^CNT_W.
idle  output  1  high when no reads are in flight and the buffer is empty.
err  output  1  sticky: rvalid arrived with no read outstanding.

Behaviour:
- Reset (rrst_n low at a rising rclk edge) sets: rinc=0, m_valid=0, m_data=0, rd_count=0, err=0, idle=1, occ=0, inflight=0, buffer pointers=0.
- rvalid is ignored while rrst_n is low.
- Internal state:
  - occ counts 0..OB_DEPTH.
  - inflight counts 0..OB_DEPTH, i.e. rinc issued but rvalid not yet seen.
  - Invariant: occ + inflight <= OB_DEPTH at all times.
- rinc is combinational: rinc = rrst_n & en & !rempty & (occ + inflight + 1 <= OB_DEPTH).
  - No registered lookahead.
  - Pops in the same cycle do not add credit; credit is freed on the cycle after a pop.
- inflight update per cycle: +1 on rinc, -1 on rvalid (when inflight>0); both together means unchanged.
- Push:
  - On rvalid with inflight>0, write rdata to the buffer at wr_ptr, advance wr_ptr modulo OB_DEPTH, and increment occ.
  - On rvalid with inflight==0, set err=1 and discard the data; occ and wr_ptr are unchanged.
  - err clears only on reset.
- Output:
  - m_valid = (occ != 0).
  - m_data = buffer[rd_ptr], driven from registers or a mux of registered entries.
  - When m_valid=0, m_data holds its last value and is don't-care to the consumer.
- Pop (m_valid & m_ready):
  - Advance rd_ptr modulo OB_DEPTH, decrement occ, and increment rd_count (wraps from 2^CNT_W-1 to 0).
- Push and pop in the same cycle leave occ unchanged.
  - When occ==0, a push and a pop cannot coincide (m_valid is 0); the pushed word becomes visible the next cycle.
- Latency: a word is visible on m_valid at the earliest 1 cycle after its rvalid; no combinational path from rvalid to m_valid.
- Buffer full (occ==OB_DEPTH) forces rinc=0 and inflight is then 0.
  - rvalid with occ==OB_DEPTH cannot occur legally; it is handled by the err rule.
- en deasserted mid-stream: no new rinc; outstanding reads still complete and are buffered; streaming continues.
- idle = (occ==0) & (inflight==0), registered view of current state.
- Reset mid-operation discards buffered and in-flight words; the FIFO read side shares rrst_n, so no stale rvalid arrives after release.
- m_valid/m_data stability: once m_valid=1, m_data does not change until the pop.

Test Plan:
- Reset then en=1, rempty=0, model FIFO with 1-cycle latency returning 0x0001..0x0008, m_ready=1 -> m_data sequence 0x0001..0x0008 in order, rd_count=8, err=0, idle=1 at end.
- m_ready=0, rempty=0 held -> exactly 4 rinc pulses total, occ=4, rinc stays 0.
  - Then m_ready=1 for 1 cycle -> one pop, rinc reasserts the following cycle, no data loss.
- rempty toggling every cycle, m_ready random 50% -> output equals input order, inflight never exceeds 4, no err.
- Inject rvalid=1 with no prior rinc, rdata=0xDEAD -> err=1 sticky, m_valid stays 0, rd_count unchanged.
- en dropped with 2 reads in flight -> both words delivered, no further rinc, idle=1 after drain.
- rrst_n low for 1 cycle with occ=3 -> next cycle m_valid=0, rd_count=0, err=0.
- rd_count preset near wrap (CNT_W=4), 17 pops -> rd_count=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO. Issues rinc against local credit,
// buffers returned words and presents them as a valid/ready stream.
module fifo_rd_stream #(
  parameter int DATA_W   = 16,
  parameter int OB_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              en,
  input  logic              rempty,
  output logic              rinc,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic              idle,
  output logic              err
);

  localparam int PTR_W = $clog2(OB_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [OB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  inflight;
  logic [DATA_W-1:0] last_data;
  logic [OCC_W:0]    credit_sum;
  logic              push;
  logic              stray;
  logic              pop;

  // Credit counts both buffered words and reads still in flight, so every
  // word that comes back on rvalid already has a slot reserved for it.
  assign credit_sum = {1'b0, occ} + {1'b0, inflight};
  assign rinc       = rrst_n & en & ~rempty & (credit_sum < (OCC_W+1)'(OB_DEPTH));

  assign push    = rrst_n & rvalid & (inflight != '0);
  assign stray   = rrst_n & rvalid & (inflight == '0);
  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  assign idle    = (occ == '0) & (inflight == '0);

  // Head of buffer while valid; otherwise hold the last presented word.
  assign m_data = m_valid ? mem[rd_ptr] : last_data;

  // Buffer storage: contents need no reset, occ qualifies them.
  always_ff @(posedge rclk) begin
    if (push) mem[wr_ptr] <= rdata;
  end

  // Pointers, occupancy, in-flight credit, counters and sticky error.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      inflight  <= '0;
      rd_count  <= '0;
      err       <= 1'b0;
      last_data <= '0;
    end else begin
      last_data <= m_data;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop)  rd_count <= rd_count + CNT_W'(1);
      if (stray) err <= 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      case ({rinc, push})
        2'b10:   inflight <= inflight + OCC_W'(1);
        2'b01:   inflight <= inflight - OCC_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a queue-based reference model.
module tb_fifo_rd_stream;
  localparam int DW  = 16;
  localparam int OBD = 4;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          en = 1'b0;
  logic          rempty = 1'b1;
  logic          rvalid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] rdata = '0;

  logic          rinc, m_valid, idle, err;
  logic [DW-1:0] m_data;
  logic [15:0]   rd_count;
  logic          rinc4, m_valid4, idle4, err4;
  logic [DW-1:0] m_data4;
  logic [3:0]    rd_count4;

  fifo_rd_stream #(.DATA_W(DW), .OB_DEPTH(OBD), .CNT_W(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rinc(rinc),
    .rdata(rdata), .rvalid(rvalid), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .rd_count(rd_count), .idle(idle), .err(err)
  );

  // Narrow-counter instance on the same stimulus exercises rd_count wrap.
  fifo_rd_stream #(.DATA_W(DW), .OB_DEPTH(OBD), .CNT_W(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rinc(rinc4),
    .rdata(rdata), .rvalid(rvalid), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .rd_count(rd_count4), .idle(idle4), .err(err4)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int            outstanding = 0;
  bit            err_m = 0;
  int            cnt = 0;
  logic [DW-1:0] last_m = '0;
  bit            exp_rinc = 0;
  // FIFO read-latency model
  bit            pv[2] = '{0, 0};
  logic [DW-1:0] pd[2] = '{16'h0, 16'h0};
  int            lat = 1;
  logic [DW-1:0] src = 16'h0001;
  int            issued = 0;
  bit            inject = 0;
  logic [DW-1:0] inj_data = '0;
  int            rinc_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [DW-1:0] exp_data;
    rvalid = pv[0] | inject;
    rdata  = inject ? inj_data : pd[0];
    @(negedge rclk);
    exp_rinc = rrst_n && en && !rempty && (q.size() + outstanding < OBD);
    exp_data = (q.size() != 0) ? q[0] : last_m;
    last_m   = exp_data;
    chk("rinc", 32'(rinc), 32'(exp_rinc));
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("m_data", 32'(m_data), 32'(exp_data));
    chk("rd_count", 32'(rd_count), 32'(cnt & 16'hFFFF));
    chk("rd_count4", 32'(rd_count4), 32'(cnt & 4'hF));
    chk("err", 32'(err), 32'(err_m));
    chk("idle", 32'(idle), 32'((q.size() == 0) && (outstanding == 0)));
    if (rinc) rinc_pulses++;
    @(posedge rclk);
    if (!rrst_n) begin
      q.delete();
      outstanding = 0;
      err_m = 0;
      cnt = 0;
      last_m = '0;
      pv = '{0, 0};
    end else begin
      if (q.size() != 0 && m_ready) begin
        void'(q.pop_front());
        cnt++;
      end
      if (rvalid) begin
        if (outstanding > 0) begin
          q.push_back(rdata);
          outstanding--;
        end else begin
          err_m = 1;
        end
      end
      pv[0] = pv[1];
      pd[0] = pd[1];
      pv[1] = 0;
      if (exp_rinc) begin
        outstanding++;
        pv[lat-1] = 1;
        pd[lat-1] = src;
        src++;
        issued++;
      end
    end
    #1;
    inject = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    en = 0;
    m_ready = 1;
    n = 0;
    while ((q.size() != 0 || outstanding != 0 || pv[0] || pv[1]) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, 32'(0), 32'(1));
    step();
  endtask

  initial begin
    int base, n, c0;
    #1;
    // Reset
    rrst_n = 0;
    step();
    step();
    rrst_n = 1;
    step();

    // Straight stream of 8 words, 1-cycle latency, consumer always ready
    base = issued;
    en = 1;
    m_ready = 1;
    for (int i = 0; i < 20; i++) begin
      rempty = (issued - base >= 8);
      step();
    end
    chk("A_count8", 32'(rd_count), 32'(8));
    chk("A_idle", 32'(idle), 32'(1));
    chk("A_err", 32'(err), 32'(0));

    // Back-pressure: exactly OB_DEPTH reads, then one pop frees one credit
    rempty = 0;
    m_ready = 0;
    rinc_pulses = 0;
    for (int i = 0; i < 10; i++) step();
    chk("B_pulses4", 32'(rinc_pulses), 32'(4));
    chk("B_full_rinc", 32'(rinc), 32'(0));
    m_ready = 1;
    step();
    m_ready = 0;
    rinc_pulses = 0;
    step();
    chk("B_refill", 32'(rinc_pulses), 32'(1));
    for (int i = 0; i < 4; i++) step();
    drain("B");

    // Random: rempty toggling, 50% ready
    en = 1;
    for (int i = 0; i < 300; i++) begin
      rempty = i[0];
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain("C");
    chk("C_err", 32'(err), 32'(0));

    // en dropped with two reads in flight (2-cycle latency)
    lat = 2;
    c0 = cnt;
    en = 1;
    rempty = 0;
    m_ready = 0;
    step();
    step();
    en = 0;
    chk("D_busy", 32'(idle), 32'(0));
    for (int i = 0; i < 4; i++) step();
    m_ready = 1;
    for (int i = 0; i < 4; i++) step();
    chk("D_delivered", 32'(rd_count), 32'((c0 + 2) & 16'hFFFF));
    chk("D_idle", 32'(idle), 32'(1));
    lat = 1;

    // Stray rvalid with nothing outstanding
    c0 = cnt;
    m_ready = 1;
    inject = 1;
    inj_data = 16'hDEAD;
    step();
    chk("E_err", 32'(err), 32'(1));
    chk("E_no_valid", 32'(m_valid), 32'(0));
    chk("E_count", 32'(rd_count), 32'(c0 & 16'hFFFF));
    step();
    chk("E_sticky", 32'(err), 32'(1));

    // Reset mid-operation with three words buffered
    m_ready = 0;
    rempty = 0;
    n = 0;
    while (q.size() < 3 && n < 20) begin
      en = (q.size() + outstanding < 3);
      step();
      n++;
    end
    if (n >= 20) chk("F_fill_timeout", 32'(0), 32'(1));
    en = 0;
    rrst_n = 0;
    step();
    rrst_n = 1;
    step();
    chk("F_m_valid", 32'(m_valid), 32'(0));
    chk("F_count", 32'(rd_count), 32'(0));
    chk("F_err", 32'(err), 32'(0));

    // 17 pops through the 4-bit counter wrap to 1
    base = issued;
    en = 1;
    m_ready = 1;
    n = 0;
    while (cnt < 17 && n < 100) begin
      rempty = (issued - base >= 17);
      step();
      n++;
    end
    drain("G");
    chk("G_wrap", 32'(rd_count4), 32'(1));
    chk("G_count17", 32'(rd_count), 32'(17));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
